// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared widths, constants and the fetch-queue entry type
// used by the instruction-fetch stage.
//   ADDR_W / INSTR_W   : byte-address and instruction-word widths
//   DEFAULT_PC_STEP    : byte increment per sequential fetch
//   NOP_INSTR          : canonical MIPS no-op encoding
//   fetch_entry_t      : {pc, instr} pair held in the fetch queue
package mips_fetch_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  DEFAULT_PC_STEP = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR       = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: bundles the fetch stage's memory, redirect and decode
// handshake signals.
//   master : fetch-unit side (drives imem_addr, out_*, perf_stall_cycles)
//   slave  : environment side (drives imem_instr, redirect_*, out_ready)
interface mips_fetch_unit_if;
    import mips_fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus4;
    logic [31:0]        perf_stall_cycles;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, perf_stall_cycles,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, perf_stall_cycles,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: circular-buffer FIFO of fetch_entry_t.
//   clk, reset : clock, synchronous active-high reset (clears storage too,
//                so the head reads all-zero out of reset)
//   push/wdata : enqueue; accepted when not full or when popping this cycle
//   pop        : dequeue head; ignored when empty
//   flush      : discard all entries (dominates push/pop)
//   full/empty : occupancy flags
//   head       : entry at the read pointer (registered storage, no bypass)
module mips_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!flush && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch stage. Owns the PC, drives the
// instruction-memory address, queues {pc, instr} pairs and hands them to
// decode via valid/ready. Redirects flush the queue and reload the PC.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mips_fetch_unit_if.master (imem_addr/imem_instr,
//                redirect_valid/redirect_pc, out_valid/out_ready,
//                out_instr/out_pc/out_pc_plus4, perf_stall_cycles)
// Optional feature macro: MIPS_FETCH_PERF_EN enables the decode-stall
// counter; otherwise perf_stall_cycles is tied to zero.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned       QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0] PC_STEP     = DEFAULT_PC_STEP
) (
    input  logic                clk,
    input  logic                reset,
    mips_fetch_unit_if.master   bus
);

    logic [ADDR_W-1:0] pc_q;
    logic              q_full;
    logic              q_empty;
    logic              pop;
    logic              push;
    fetch_entry_t      q_head;
    fetch_entry_t      q_wdata;

    assign pop     = ~q_empty & bus.out_ready;
    assign push    = ~bus.redirect_valid & (~q_full | pop);
    assign q_wdata = '{pc: pc_q, instr: bus.imem_instr};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc_q <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    mips_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata (q_wdata),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head)
    );

    assign bus.imem_addr    = pc_q;
    assign bus.out_valid    = ~q_empty;
    assign bus.out_instr    = q_head.instr;
    assign bus.out_pc       = q_head.pc;
    assign bus.out_pc_plus4 = q_head.pc + 32'd4;

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (~q_empty && !bus.out_ready && !bus.redirect_valid && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.perf_stall_cycles = stall_q;
`else
    assign bus.perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
    import mips_fetch_pkg::*;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    fetch_entry_t exp_a[$];
    fetch_entry_t exp_b[$];

    mips_fetch_unit_if bus_a ();
    mips_fetch_unit_if bus_b ();

    mips_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2),
        .PC_STEP     (32'd4)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.master)
    );

    mips_fetch_unit #(
        .RESET_PC    (32'hFFFF_FFF8),
        .QUEUE_DEPTH (2),
        .PC_STEP     (32'd4)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.master)
    );

    // Instruction memory model: mem[i] = 0x1000_0000 + i
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign bus_a.imem_instr = mem_word(bus_a.imem_addr);
    assign bus_b.imem_instr = mem_word(bus_b.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input logic [31:0] pc);
        exp_a.push_back('{pc: pc, instr: mem_word(pc)});
    endtask

    task automatic expect_b(input logic [31:0] pc);
        exp_b.push_back('{pc: pc, instr: mem_word(pc)});
    endtask

    // Scoreboard monitors: compare on every completed handshake.
    fetch_entry_t ea;
    always @(negedge clk) begin
        if (!rst_a && bus_a.out_valid && bus_a.out_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_a_unexpected actual_pc=%h expected=none", bus_a.out_pc);
            end else begin
                ea = exp_a.pop_front();
                check("mon_a_pc", bus_a.out_pc, ea.pc);
                check("mon_a_instr", bus_a.out_instr, ea.instr);
                check("mon_a_pc_plus4", bus_a.out_pc_plus4, ea.pc + 32'd4);
            end
        end
    end

    fetch_entry_t eb;
    always @(negedge clk) begin
        if (!rst_b && bus_b.out_valid && bus_b.out_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_b_unexpected actual_pc=%h expected=none", bus_b.out_pc);
            end else begin
                eb = exp_b.pop_front();
                check("mon_b_pc", bus_b.out_pc, eb.pc);
                check("mon_b_instr", bus_b.out_instr, eb.instr);
                check("mon_b_pc_plus4", bus_b.out_pc_plus4, eb.pc + 32'd4);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.out_ready      = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        bus_b.out_ready      = 1'b0;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = '0;
        repeat (2) tick();

        // Reset state
        check("rst_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        check("rst_out_instr", bus_a.out_instr, 32'd0);
        check("rst_out_pc", bus_a.out_pc, 32'd0);
        check("rst_out_pc_plus4", bus_a.out_pc_plus4, 32'd4);
        check("rst_imem_addr", bus_a.imem_addr, 32'd0);
        check("rst_perf", bus_a.perf_stall_cycles, 32'd0);

        // Streaming with out_ready=1: 0,4,8,12,16 one per cycle
        for (int unsigned i = 0; i < 5; i++) expect_a(32'(i * 4));
        rst_a = 1'b0;
        bus_a.out_ready = 1'b1;
        check("stream_valid_c0", {31'b0, bus_a.out_valid}, 32'd0);
        tick();
        check("stream_valid_c1", {31'b0, bus_a.out_valid}, 32'd1);
        repeat (5) tick();
        bus_a.out_ready = 1'b0;
        rst_a = 1'b1;
        repeat (2) tick();
        check("stream_drained", 32'(exp_a.size()), 32'd0);

        // Decode stall: queue fills, pc holds at 8, head holds pc 0
        rst_a = 1'b0;
        tick();
        check("stall_valid_c1", {31'b0, bus_a.out_valid}, 32'd1);
        repeat (2) tick();
        check("stall_imem_addr_c3", bus_a.imem_addr, 32'h8);
        check("stall_out_pc_c3", bus_a.out_pc, 32'h0);
        repeat (3) tick();
        check("stall_imem_addr_c6", bus_a.imem_addr, 32'h8);
        check("stall_out_pc_c6", bus_a.out_pc, 32'h0);
        check("stall_out_instr_c6", bus_a.out_instr, 32'h1000_0000);
`ifdef MIPS_FETCH_PERF_EN
        check("stall_perf", bus_a.perf_stall_cycles, 32'd5);
`else
        check("stall_perf", bus_a.perf_stall_cycles, 32'd0);
`endif
        expect_a(32'h0);
        expect_a(32'h4);
        expect_a(32'h8);
        bus_a.out_ready = 1'b1;
        tick();
        check("release_valid_c7", {31'b0, bus_a.out_valid}, 32'd1);
        tick();
        check("release_valid_c8", {31'b0, bus_a.out_valid}, 32'd1);
        tick();
        bus_a.out_ready = 1'b0;
        check("release_drained", 32'(exp_a.size()), 32'd0);

        // Redirect to 0x40 with a full queue
        check("redir_pre_valid", {31'b0, bus_a.out_valid}, 32'd1);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h40;
        tick();
        bus_a.redirect_valid = 1'b0;
        check("redir_valid_n1", {31'b0, bus_a.out_valid}, 32'd0);
        check("redir_imem_addr", bus_a.imem_addr, 32'h40);
        expect_a(32'h40);
        tick();
        check("redir_valid_n2", {31'b0, bus_a.out_valid}, 32'd1);
        check("redir_out_pc_n2", bus_a.out_pc, 32'h40);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;

        // Misaligned redirect target
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h47;
        tick();
        bus_a.redirect_valid = 1'b0;
        check("misalign_imem_addr", bus_a.imem_addr, 32'h44);
        check("misalign_valid", {31'b0, bus_a.out_valid}, 32'd0);
        expect_a(32'h44);
        tick();
        check("misalign_out_pc", bus_a.out_pc, 32'h44);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;

        // Back-to-back redirects: 0x20 then 0x80, only 0x80 stream appears
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h20;
        tick();
        bus_a.redirect_pc    = 32'h80;
        bus_a.out_ready      = 1'b1;
        check("b2b_valid_1", {31'b0, bus_a.out_valid}, 32'd0);
        tick();
        bus_a.redirect_valid = 1'b0;
        check("b2b_valid_2", {31'b0, bus_a.out_valid}, 32'd0);
        check("b2b_imem_addr", bus_a.imem_addr, 32'h80);
        expect_a(32'h80);
        expect_a(32'h84);
        expect_a(32'h88);
        repeat (4) tick();
        bus_a.out_ready = 1'b0;
        check("b2b_drained", 32'(exp_a.size()), 32'd0);

        // Reset with a full queue and a concurrent redirect
        repeat (2) tick();
        check("rstmid_pre_valid", {31'b0, bus_a.out_valid}, 32'd1);
        rst_a = 1'b1;
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h100;
        bus_a.out_ready      = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.redirect_valid = 1'b0;
        bus_a.out_ready      = 1'b0;
        check("rstmid_valid", {31'b0, bus_a.out_valid}, 32'd0);
        check("rstmid_imem_addr", bus_a.imem_addr, 32'h0);
        check("rstmid_perf", bus_a.perf_stall_cycles, 32'd0);
        check("rstmid_out_pc", bus_a.out_pc, 32'h0);
        tick();
        check("rstmid_restart_pc", bus_a.out_pc, 32'h0);

        // Wrap-around from RESET_PC=0xFFFF_FFF8
        expect_b(32'hFFFF_FFF8);
        expect_b(32'hFFFF_FFFC);
        expect_b(32'h0000_0000);
        rst_b = 1'b0;
        bus_b.out_ready = 1'b1;
        check("wrap_imem_addr_c0", bus_b.imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_out_pc_c1", bus_b.out_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_out_pc_c2", bus_b.out_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4_c2", bus_b.out_pc_plus4, 32'h0);
        tick();
        check("wrap_out_pc_c3", bus_b.out_pc, 32'h0);
        tick();
        bus_b.out_ready = 1'b0;
        check("wrap_drained", 32'(exp_b.size()), 32'd0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the memory's byte address. It captures the returned 32-bit word, together with its PC, into a 2-entry fetch queue. Decode drains the queue through a valid/ready handshake. Branch/jump redirects from execute flush the queue and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
QUEUE_DEPTH, 2, fetch-queue entries; legal values 2 or 4
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  32  byte address to instruction memory (word index = addr>>2)
imem_instr  in  32  combinational read data for imem_addr, valid in the same cycle
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  32  target byte address
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instr  out  32  head instruction word
out_pc  out  32  head instruction byte address
out_pc_plus4  out  32  out_pc + 4, modulo 2^32
perf_stall_cycles  out  32  count of cycles with out_valid=1 and out_ready=0 (optional feature)

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - pc <= RESET_PC; queue emptied.
  - out_valid=0; out_instr=0; out_pc=0; out_pc_plus4=4; perf_stall_cycles=0.
  - Reset mid-operation discards all queued entries. No output handshake completes in the reset cycle.
- imem_addr = pc register, direct. No combinational path from any input to imem_addr.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < QUEUE_DEPTH | pop). Pushed entry = {pc, imem_instr}.
- On push: pc <= pc + PC_STEP, wrapping modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Full queue with no pop: no push, pc held, imem_addr stable.
- Simultaneous push and pop when full is legal; count unchanged.
- Latency: pc=A in cycle N → entry {A, mem[A>>2]} at the head with out_valid=1 in cycle N+1 if the queue was empty.
- Output ordering is strict FIFO. out_* are driven from the head register with no input-to-output combinational path.
- Holding rule: while out_valid=1 and out_ready=0, out_instr, out_pc and out_pc_plus4 hold stable.
- Redirect (redirect_valid=1):
  - Queue cleared.
  - pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently cleared.
  - No push that cycle.
  - A pop coinciding with the redirect counts as consumed by decode; the flush still clears all entries.
  - out_valid=0 in the cycle after the redirect. The target instruction appears at the head 2 cycles after redirect_valid.
- Back-to-back redirects: the last one wins. Each cycle reloads pc and keeps the queue empty.
- Queue implemented as circular buffer: rd/wr pointers of log2(QUEUE_DEPTH) bits plus count of log2(QUEUE_DEPTH)+1 bits; pointers wrap at QUEUE_DEPTH.

Optional Feature:
- Macro: MIPS_FETCH_PERF_EN.
- Defined: perf_stall_cycles increments when out_valid & !out_ready & !redirect_valid. Saturates at 32'hFFFF_FFFF. Cleared only by reset.
- Undefined: counter logic absent; perf_stall_cycles tied to 32'h0. Port list identical in both builds.

Decomposition:
- Package mips_fetch_pkg:
  - ADDR_W=32, INSTR_W=32, PC_STEP default.
  - NOP_INSTR=32'h0000_0000.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module mips_fetch_queue: generic FIFO of fetch_entry_t with push, pop, flush, full, empty, head. The top level holds the PC, push/redirect logic and the perf counter.

Test Plan:
- Reset then out_ready=1 for 6 cycles, mem[i]=32'h1000_0000+i, RESET_PC=0 → out_valid rises cycle 1; out_pc 0,4,8,12,16; out_instr 32'h1000_0000..32'h1000_0004, one per cycle.
- out_ready=0 for 5 cycles after 1st fetch:
  - queue fills to 2; imem_addr holds at 8; out_pc holds 0.
  - with MIPS_FETCH_PERF_EN, perf_stall_cycles=5.
  - release out_ready → 0,4,8 delivered in order, no gaps, no duplicates.
- redirect_valid=1, redirect_pc=32'h40 with 2 entries queued → next cycle out_valid=0 and imem_addr=32'h40; 2 cycles later out_pc=32'h40.
- redirect_pc=32'h47 → imem_addr=32'h44.
- Back-to-back redirects to 32'h20 then 32'h80 → only 32'h80 stream delivered; no 32'h20 entry ever valid.
- RESET_PC=32'hFFFF_FFF8, out_ready=1 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc_plus4 at FFFF_FFFC equals 0.
- reset asserted with 2 queued entries and a concurrent redirect → next cycle out_valid=0, imem_addr=RESET_PC, perf_stall_cycles=0.
